// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: 2^ADDR_W x DATA_W MIPS register file.
// Two combinational read ports (rs, rt) and one synchronous write port.
// Register 0 always reads as zero. After reset a sequencer zeroes one entry
// per cycle, so the array needs no global clear and can map to distributed
// RAM. busy is high while that sweep runs; writes are ignored meanwhile.
// Optional build macro: REGFILE_BYPASS_EN adds write-through forwarding
// from the write port to matching read ports in the same cycle.

// One read port: applies the zero rules and, when built in, forwarding.
module regfile_rd_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] entry,
  input  logic              init,
`ifdef REGFILE_BYPASS_EN
  input  logic              fwd_hit,
  input  logic [DATA_W-1:0] fwd_data,
`endif
  output logic [DATA_W-1:0] data
);

  // Register 0 and the INIT state force zero ahead of any forwarding.
  always_comb begin
    data = entry;
    if (addr == '0 || init) data = '0;
`ifdef REGFILE_BYPASS_EN
    else if (fwd_hit) data = fwd_data;
`endif
  end

endmodule

module regfile_clr_seq #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  localparam int NUM_RD = 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  // Single write request into the array: either a clear or a user write.
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  wr_req_t           wreq;
  logic              init;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_entry;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_dat;

  assign init = (state == S_INIT);

  // Clear sequencer: sweep every entry once after reset, then run.
  // The terminal compare hands over to RUN so the counter never re-enters INIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_INIT;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        S_INIT: begin
          if (clr_cnt == CLR_LAST) begin
            state   <= S_RUN;
            clr_cnt <= '0;
            busy    <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        S_RUN: begin
          busy <= 1'b0;
        end
        default: begin
          state   <= S_INIT;
          clr_cnt <= '0;
          busy    <= 1'b1;
        end
      endcase
    end
  end

  // Select the array write: clearing owns the port in INIT; in RUN only
  // non-zero addresses are stored, keeping entry 0 permanently clear.
  always_comb begin
    wreq = '0;
    if (init) begin
      wreq.en   = 1'b1;
      wreq.addr = clr_cnt;
      wreq.data = '0;
    end else if (wr_en && wr_addr != '0) begin
      wreq.en   = 1'b1;
      wreq.addr = wr_addr;
      wreq.data = wr_data;
    end
  end

  // Storage array; no reset so it maps onto plain distributed RAM.
  // A reset edge must not write, so the request is gated by rst_n.
  always_ff @(posedge clk) begin
    if (rst_n && wreq.en) mem[wreq.addr] <= wreq.data;
  end

  assign rd_addr[0] = rs_addr;
  assign rd_addr[1] = rt_addr;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rd_entry[p] = mem[rd_addr[p]];

`ifdef REGFILE_BYPASS_EN
    logic fwd_hit;
    assign fwd_hit = wr_en && (wr_addr != '0) && (wr_addr == rd_addr[p]);
`endif

    regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rd (
      .addr     (rd_addr[p]),
      .entry    (rd_entry[p]),
      .init     (init),
`ifdef REGFILE_BYPASS_EN
      .fwd_hit  (fwd_hit),
      .fwd_data (wr_data),
`endif
      .data     (rd_dat[p])
    );
  end

  assign rd_data1 = rd_dat[0];
  assign rd_data2 = rd_dat[1];

endmodule

// File: tb/tb_regfile_clr_seq.sv
// tb_regfile_clr_seq: randomized + directed bench for regfile_clr_seq,
// checked against a behavioural model (array + remaining-clear countdown).
module tb_regfile_clr_seq;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rs_addr, rt_addr, wr_addr;
  logic [DW-1:0] rd_data1, rd_data2, wr_data;
  logic          wr_en;
  logic          busy;

  int n_checks = 0;
  int n_errs   = 0;

  // Model: contents, whether we are clearing, cycles of clear left.
  logic [DW-1:0] model [DEPTH];
  bit            m_valid = 0;
  bit            m_init  = 0;
  int            m_left  = 0;

  always #5 clk = ~clk;

  regfile_clr_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (m_init || a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr != '0 && wr_addr == a) return wr_data;
`endif
    return model[a];
  endfunction

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cyc();
    @(negedge clk);
    if (m_valid) begin
      chk("busy", {31'b0, busy}, {31'b0, m_init});
      chk("rd1", rd_data1, exp_rd(rs_addr));
      chk("rd2", rd_data2, exp_rd(rt_addr));
    end
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1;
      m_init  = 1;
      m_left  = DEPTH;
    end else if (m_valid && m_init) begin
      m_left--;
      if (m_left == 0) begin
        m_init = 0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
      end
    end else if (m_valid && wr_en && wr_addr != '0) begin
      model[wr_addr] = wr_data;
    end
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  // Release reset and count busy cycles; the sweep must take DEPTH cycles.
  task automatic release_and_count(input string tag);
    int cnt = 0;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      #3;
      if (busy) cnt++;
      cyc();
    end
    chk(tag, cnt, DEPTH);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rs_addr = 5'd5; rt_addr = 5'd31;

    // Reset then clear, with writes to addr 3 attempted during INIT.
    cyc(); cyc();
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_rd1", rd_data1, 32'd0);
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAAAA5555;
    for (int i = 0; i < 10; i++) cyc();
    wr_en = 1'b0;
    rst_n = 1'b0; cyc();
    release_and_count("clr_len");
    chk("run_busy", {31'b0, busy}, 32'd0);
    rs_addr = 5'd3; #1;
    chk("init_wr_ignored", rd_data1, 32'd0);
    cyc();

    // Basic write/read.
    wr(5'd8, 32'hDEADBEEF);
    wr(5'd31, 32'h12345678);
    rs_addr = 5'd8; rt_addr = 5'd31; #1;
    chk("basic_rd1", rd_data1, 32'hDEADBEEF);
    chk("basic_rd2", rd_data2, 32'h12345678);
    cyc();

    // $zero protection.
    wr(5'd0, 32'hFFFFFFFF);
    rs_addr = 5'd0; #1;
    chk("zero_rd", rd_data1, 32'd0);
    cyc();

    // Same-cycle read/write.
    wr(5'd9, 32'h1);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h2; rs_addr = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
    chk("same_cyc", rd_data1, 32'h2);
`else
    chk("same_cyc", rd_data1, 32'h1);
`endif
    cyc();
    wr_en = 1'b0; #1;
    chk("after_edge", rd_data1, 32'h2);
    rt_addr = 5'd9; #1;
    chk("both_same", rd_data2, rd_data1 === 32'h2 ? 32'h2 : 32'hx);
    cyc();

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_data = $urandom;
      rs_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
      rt_addr = AW'($urandom_range(0, DEPTH - 1));
      cyc();
    end
    rst_n = 1'b1; wr_en = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) cyc();

    // Fill everything, then mid-run reset; every entry must read back zero.
    for (int a = 1; a < DEPTH; a++) wr(AW'(a), $urandom | 32'h1);
    wr(5'd4, 32'h11);
    rs_addr = 5'd4; #1;
    chk("pre_rst", rd_data1, 32'h11);
    rst_n = 1'b0; cyc();
    release_and_count("clr_len_mid");
    rs_addr = 5'd4; #1;
    chk("mid_rst_a4", rd_data1, 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      rs_addr = AW'(a); rt_addr = AW'(DEPTH - 1 - a);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/regfile_clr_seq.md
Name: regfile_clr_seq

Overview:
- 2^ADDR_W x DATA_W MIPS register file that sits directly downstream of the write-register select mux: the 5-bit mux output drives wr_addr.
- Two asynchronous read ports (rs, rt) and one synchronous write port.
- Register 0 is hardwired to zero.
- After reset, a sequencer clears the array one entry per cycle, so the storage maps to distributed RAM without a global clear; busy is asserted while clearing.

Parameters:
DATA_W, 32, data width of each register
ADDR_W, 5, address width; depth = 2^ADDR_W (matches the 5-bit register-select mux)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
rs_addr  input  ADDR_W  read port 1 address
rt_addr  input  ADDR_W  read port 2 address
rd_data1  output  DATA_W  read port 1 data
rd_data2  output  DATA_W  read port 2 data
wr_en  input  1  write enable (RegWrite)
wr_addr  input  ADDR_W  write address (from the RegDst mux)
wr_data  input  DATA_W  write data
busy  output  1  high while the clear sequence runs; writes ignored

Behaviour:
- One clock; reset is synchronous and active-low, sampled on the rising edge of clk.
- State machine, two states: INIT, RUN.
- While rst_n=0 at an edge:
  - state<=INIT, clr_cnt<=0.
  - No array write occurs on that edge.
  - busy reads 1 in the following cycle.
- INIT:
  - Each edge with rst_n=1: entry[clr_cnt]<=0, then clr_cnt<=clr_cnt+1.
  - When clr_cnt = 2^ADDR_W-1 is written: state<=RUN.
  - Clear takes exactly 2^ADDR_W cycles after reset release (32 by default).
  - busy=1 throughout INIT.
  - wr_en is ignored.
  - rd_data1/rd_data2 = 0 regardless of address.
- RUN:
  - busy=0.
  - On an edge with wr_en=1 and wr_addr!=0: entry[wr_addr]<=wr_data.
  - wr_addr=0 writes are discarded.
- Reads (combinational, zero latency):
  - rd_dataN = 0 if its address = 0 or state = INIT; otherwise rd_dataN = entry[addr].
- Read/write same address, same cycle (RUN): the read returns the old value; the new value is visible after the edge (write-first is only with the optional feature).
- Both read ports may address the same entry; both return the same value.
- Reset mid-operation (in INIT or RUN): the clear restarts from entry 0; contents written before reset are lost once re-cleared.
- clr_cnt is ADDR_W+1 bits wide or uses an explicit terminal compare; no wrap back into INIT.
- No X on outputs after the first reset edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in RUN, if wr_en=1, wr_addr!=0 and wr_addr equals rs_addr (or rt_addr), the corresponding rd_data output shows wr_data combinationally in the same cycle (write-through forwarding).
  - The register-0 and INIT rules still take priority.
- Undefined: no forwarding logic is synthesized; same-cycle reads return the old contents.

Test Plan:
- Reset then clear:
  - Stimulus: hold rst_n=0 for 2 cycles, release; read rs_addr=5 and rt_addr=31 every cycle.
  - Response: busy=1 for exactly 32 cycles, then 0; rd_data1=rd_data2=0 throughout.
- Basic write/read:
  - Stimulus: in RUN, write 0xDEADBEEF to addr 8, then 0x12345678 to addr 31; next cycle set rs_addr=8, rt_addr=31.
  - Response: rd_data1=0xDEADBEEF, rd_data2=0x12345678.
- $zero protection:
  - Stimulus: write 0xFFFFFFFF to addr 0; read rs_addr=0.
  - Response: rd_data1=0.
- Writes ignored during INIT:
  - Stimulus: at reset release, wr_en=1, wr_addr=3, wr_data=0xAAAA5555 for 10 cycles; after busy falls, read addr 3.
  - Response: rd_data1=0.
- Mid-run reset:
  - Stimulus: write 0x11 to addr 4; pulse rst_n=0 for 1 cycle; read addr 4.
  - Response: busy=1 again for 32 cycles; afterwards addr 4 reads 0.
- Same-cycle read/write:
  - Stimulus: addr 9 holds 0x1; in one cycle wr_en=1, wr_addr=9, wr_data=0x2, rs_addr=9.
  - Response: rd_data1=0x1 during the cycle and 0x2 after the edge; with REGFILE_BYPASS_EN defined, rd_data1=0x2 during the cycle.
